// File: rtl/crypto_pkg.sv
// Shared constants for the zigzag encryption/decryption blocks: token, buffer depth,
// index width and FSM state encoding.
package crypto_pkg;
  localparam int         MAX_NOF_CHARS          = 50;
  localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;
  localparam int         IDX_W                  = $clog2(MAX_NOF_CHARS + 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_TOKEN   = 2'd2
  } zz_state_e;
endpackage

// File: rtl/zigzag_encryption_if.sv
// Byte-stream bus of the zigzag encryption engine: plaintext in, ciphertext out.
interface zigzag_encryption_if #(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
);
  logic [D_WIDTH-1:0]   data_i;
  logic                 valid_i;
  logic [KEY_WIDTH-1:0] key;
  logic                 busy;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;

  modport master (output data_i, valid_i, key, input  busy, data_o, valid_o);
  modport slave  (input  data_i, valid_i, key, output busy, data_o, valid_o);
endinterface

// File: rtl/zigzag_rail_walker.sv
// Next-position logic for walking the rails of a zigzag: given the current rail,
// index and step phase, produce the next position or flag the last byte.
module zigzag_rail_walker
  import crypto_pkg::*;
(
  input  logic [IDX_W-1:0] n_i,
  input  logic [IDX_W-1:0] k_i,
  input  logic [IDX_W-1:0] rail_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             phase_i,
  output logic [IDX_W-1:0] rail_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             phase_o,
  output logic             last_o
);
  // Bottom rail at K=N=50 can reach idx+P = 49+98, so two extra bits keep the sum exact.
  localparam int SUM_W = IDX_W + 2;

  logic [SUM_W-1:0] n_w, k_w, r_w, period, step, sum;
  logic             linear;

  always_comb begin
    n_w    = SUM_W'(n_i);
    k_w    = SUM_W'(k_i);
    r_w    = SUM_W'(rail_i);
    linear = (k_i < IDX_W'(2));
    period = (k_w - SUM_W'(1)) << 1;
    if (linear)                                step = SUM_W'(1);
    else if (rail_i == '0 || r_w == k_w - SUM_W'(1)) step = period;
    else if (phase_i)                          step = r_w << 1;
    else                                       step = period - (r_w << 1);
    sum = SUM_W'(idx_i) + step;

    rail_o  = rail_i;
    idx_o   = idx_i;
    phase_o = phase_i;
    last_o  = 1'b0;
    if (sum < n_w) begin
      idx_o   = sum[IDX_W-1:0];
      phase_o = ~phase_i;
    end else if (linear || r_w == k_w - SUM_W'(1)) begin
      last_o  = 1'b1;
    end else begin
      rail_o  = rail_i + 1'b1;
      idx_o   = rail_i + 1'b1;
      phase_o = 1'b0;
    end
  end
endmodule

// File: rtl/zigzag_encryption.sv
// Rail-fence encryption engine: buffers plaintext until the token, then emits it in
// rail order. ZIGZAG_ENCRYPTION_TOKEN_ECHO_EN appends the token after the ciphertext.
module zigzag_encryption
  import crypto_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int KEY_WIDTH = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  zigzag_encryption_if.slave bus
);
  localparam int CMP_W = (KEY_WIDTH > IDX_W) ? KEY_WIDTH : IDX_W;

  zz_state_e          state_q, state_d;
  logic [IDX_W-1:0]   n_q, n_d, k_q, k_d, rail_q, rail_d, idx_q, idx_d;
  logic               phase_q, phase_d, busy_q, busy_d, valid_q, valid_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic [D_WIDTH-1:0] buf_q [MAX_NOF_CHARS];
  logic               wr_en, is_token;
  logic [CMP_W-1:0]   key_c, n_c;
  logic [IDX_W-1:0]   k_sel, w_rail, w_idx;
  logic               w_phase, w_last;

  zigzag_rail_walker u_walker (
    .n_i    (n_q),
    .k_i    (k_q),
    .rail_i (rail_q),
    .idx_i  (idx_q),
    .phase_i(phase_q),
    .rail_o (w_rail),
    .idx_o  (w_idx),
    .phase_o(w_phase),
    .last_o (w_last)
  );

  // Clamping K to N guarantees no empty rail during the walk.
  assign key_c    = CMP_W'(bus.key);
  assign n_c      = CMP_W'(n_q);
  assign k_sel    = (key_c < n_c) ? IDX_W'(key_c) : n_q;
  assign is_token = (bus.data_i == D_WIDTH'(START_DECRYPTION_TOKEN));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    rail_d  = rail_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    data_d  = '0;
    wr_en   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (bus.valid_i) begin
          if (is_token) begin
            state_d = ST_EMIT;
            k_d     = k_sel;
            rail_d  = '0;
            idx_d   = '0;
            phase_d = 1'b0;
            busy_d  = 1'b1;
            if (n_q != '0) begin
              valid_d = 1'b1;
              data_d  = buf_q[0];
            end
          end else if (n_q < IDX_W'(MAX_NOF_CHARS)) begin
            wr_en = 1'b1;
            n_d   = n_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (n_q == '0 || w_last) begin
`ifdef ZIGZAG_ENCRYPTION_TOKEN_ECHO_EN
          state_d = ST_TOKEN;
          valid_d = 1'b1;
          data_d  = D_WIDTH'(START_DECRYPTION_TOKEN);
`else
          state_d = ST_COLLECT;
          busy_d  = 1'b0;
          n_d     = '0;
`endif
        end else begin
          rail_d  = w_rail;
          idx_d   = w_idx;
          phase_d = w_phase;
          valid_d = 1'b1;
          data_d  = buf_q[w_idx];
        end
      end
`ifdef ZIGZAG_ENCRYPTION_TOKEN_ECHO_EN
      ST_TOKEN: begin
        state_d = ST_COLLECT;
        busy_d  = 1'b0;
        n_d     = '0;
      end
`endif
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      n_q     <= '0;
      k_q     <= '0;
      rail_q  <= '0;
      idx_q   <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      rail_q  <= rail_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Buffer is pure storage; N going to 0 on reset is what discards its contents.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[n_q] <= bus.data_i;
  end

  assign bus.busy    = busy_q;
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
endmodule

// File: tb/tb_zigzag_encryption.sv
// Directed bench for zigzag_encryption; expectations follow the echo macro when defined.
module tb_zigzag_encryption;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zigzag_encryption_if #(.D_WIDTH(8), .KEY_WIDTH(8)) zif ();
  zigzag_encryption #(.D_WIDTH(8), .KEY_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (zif)
  );

  int passed = 0;
  int total  = 0;

`ifdef ZIGZAG_ENCRYPTION_TOKEN_ECHO_EN
  localparam int ECHO = 1;
`else
  localparam int ECHO = 0;
`endif

  function automatic string with_echo(input string s);
    return (ECHO != 0) ? $sformatf("%s%c", s, 8'hFA) : s;
  endfunction

  task automatic drive_msg(input string s, input logic [7:0] k, input bit no_wait);
    for (int i = 0; i < s.len(); i++) begin
      if (!(no_wait && i == 0)) @(negedge clk);
      zif.valid_i = 1'b1;
      zif.data_i  = s[i];
      zif.key     = k;
    end
    if (!(no_wait && s.len() == 0)) @(negedge clk);
    zif.valid_i = 1'b1;
    zif.data_i  = 8'hFA;
    zif.key     = k;
  endtask

  // Samples every negedge from the one after the token edge until busy drops.
  task automatic capture(input logic [7:0] key_after, input bit junk, output string got,
                         output int busy_cyc, output int gaps, output int zero_bad,
                         output bit timeout);
    got = ""; busy_cyc = 0; gaps = 0; zero_bad = 0; timeout = 1'b1;
    @(negedge clk);
    zif.valid_i = 1'b0;
    zif.data_i  = 8'h00;
    zif.key     = key_after;
    for (int c = 0; c < 200; c++) begin
      if (zif.valid_o === 1'b0 && zif.data_o !== 8'h00) zero_bad++;
      if (zif.busy !== 1'b1) begin
        timeout = 1'b0;
        break;
      end
      busy_cyc++;
      if (zif.valid_o === 1'b1) got = $sformatf("%s%c", got, zif.data_o);
      else gaps++;
      if (junk) begin
        zif.valid_i = 1'b1;
        zif.data_i  = c[0] ? 8'hFA : 8'h5A;
      end
      @(negedge clk);
    end
    zif.valid_i = 1'b0;
  endtask

  task automatic test_reset();
    zif.valid_i = 1'b0; zif.data_i = 8'h00; zif.key = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (zif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", zif.busy); else passed++;
    total++; if (zif.valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", zif.valid_o); else passed++;
    total++; if (zif.data_o !== 8'h00) $display("FAIL reset_data got %h want 00", zif.data_o); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    string got; int bc, gp, zb; bit to;
    drive_msg("ABCDEFG", 8'd3, 1'b0);
    capture(8'd3, 1'b0, got, bc, gp, zb, to);
    total++; if (to !== 1'b0) $display("FAIL basic_timeout busy never fell"); else passed++;
    total++; if (got != with_echo("AEBDFCG")) $display("FAIL basic_data got '%s' want '%s'", got, with_echo("AEBDFCG")); else passed++;
    total++; if (bc !== 7 + ECHO) $display("FAIL basic_busy_cycles got %0d want %0d", bc, 7 + ECHO); else passed++;
    total++; if (gp !== 0) $display("FAIL basic_gaps got %0d want 0", gp); else passed++;
    total++; if (zb !== 0) $display("FAIL basic_data_zero got %0d nonzero idle samples want 0", zb); else passed++;
  endtask

  task automatic test_key_change();
    string got; int bc, gp, zb; bit to;
    drive_msg("HELLO", 8'd2, 1'b0);
    capture(8'd5, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("HLOEL")) $display("FAIL keychg_data got '%s' want '%s'", got, with_echo("HLOEL")); else passed++;
    total++; if (bc !== 5 + ECHO) $display("FAIL keychg_busy_cycles got %0d want %0d", bc, 5 + ECHO); else passed++;
  endtask

  task automatic test_key_clamp();
    string got; int bc, gp, zb; bit to;
    drive_msg("ABC", 8'd1, 1'b0);
    capture(8'd1, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("ABC")) $display("FAIL key1_data got '%s' want '%s'", got, with_echo("ABC")); else passed++;
    drive_msg("ABC", 8'd9, 1'b0);
    capture(8'd9, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("ABC")) $display("FAIL key9_data got '%s' want '%s'", got, with_echo("ABC")); else passed++;
    total++; if (bc !== 3 + ECHO) $display("FAIL key9_busy_cycles got %0d want %0d", bc, 3 + ECHO); else passed++;
  endtask

  task automatic test_empty();
    string got; int bc, gp, zb; bit to;
    drive_msg("", 8'd2, 1'b0);
    capture(8'd2, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("")) $display("FAIL empty_data got '%s' want '%s'", got, with_echo("")); else passed++;
    total++; if (bc !== 1 + ECHO) $display("FAIL empty_busy_cycles got %0d want %0d", bc, 1 + ECHO); else passed++;
    total++; if (gp !== 1) $display("FAIL empty_gaps got %0d want 1", gp); else passed++;
    total++; if (zb !== 0) $display("FAIL empty_data_zero got %0d want 0", zb); else passed++;
  endtask

  task automatic test_overflow();
    string msg, exp, got; int bc, gp, zb; bit to;
    msg = ""; exp = "";
    for (int i = 0; i < 55; i++) msg = $sformatf("%s%c", msg, 8'h20 + i);
    for (int j = 0; j < 25; j++) exp = $sformatf("%s%c", exp, 8'h20 + 2 * j);
    for (int j = 0; j < 25; j++) exp = $sformatf("%s%c", exp, 8'h21 + 2 * j);
    drive_msg(msg, 8'd2, 1'b0);
    capture(8'd2, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo(exp)) $display("FAIL overflow_data got '%s' want '%s'", got, with_echo(exp)); else passed++;
    total++; if (bc !== 50 + ECHO) $display("FAIL overflow_busy_cycles got %0d want %0d", bc, 50 + ECHO); else passed++;
  endtask

  task automatic test_busy_ignore();
    string got; int bc, gp, zb; bit to;
    drive_msg("ABCD", 8'd2, 1'b0);
    capture(8'd2, 1'b1, got, bc, gp, zb, to);
    total++; if (got != with_echo("ACBD")) $display("FAIL ignore_data got '%s' want '%s'", got, with_echo("ACBD")); else passed++;
    drive_msg("XY", 8'd2, 1'b0);
    capture(8'd2, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("XY")) $display("FAIL ignore_after_data got '%s' want '%s'", got, with_echo("XY")); else passed++;
  endtask

  // First byte of the next message is presented in the cycle busy falls.
  task automatic test_back_to_back();
    string got; int bc, gp, zb; bit to;
    drive_msg("PQ", 8'd2, 1'b1);
    capture(8'd2, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("PQ")) $display("FAIL b2b_data got '%s' want '%s'", got, with_echo("PQ")); else passed++;
  endtask

  task automatic test_reset_mid();
    string got; int bc, gp, zb, stray; bit to;
    drive_msg("ABCDEFG", 8'd3, 1'b0);
    @(negedge clk);
    zif.valid_i = 1'b0;
    got = "";
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      if (zif.valid_o === 1'b1) got = $sformatf("%s%c", got, zif.data_o);
    end
    total++; if (got != "AEB") $display("FAIL midrst_prefix got '%s' want 'AEB'", got); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (zif.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", zif.busy); else passed++;
    total++; if (zif.valid_o !== 1'b0) $display("FAIL midrst_valid got %b want 0", zif.valid_o); else passed++;
    total++; if (zif.data_o !== 8'h00) $display("FAIL midrst_data got %h want 00", zif.data_o); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (zif.busy !== 1'b0 || zif.valid_o !== 1'b0) stray++;
    end
    total++; if (stray !== 0) $display("FAIL midrst_no_resume got %0d active samples want 0", stray); else passed++;
    drive_msg("AB", 8'd2, 1'b0);
    capture(8'd2, 1'b0, got, bc, gp, zb, to);
    total++; if (got != with_echo("AB")) $display("FAIL midrst_next_data got '%s' want '%s'", got, with_echo("AB")); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_key_change();
    test_key_clamp();
    test_empty();
    test_overflow();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
